// File: rtl/bpm_history_buffer.sv
// bpm_history_buffer: circular history of the last 2^DEPTH_LOG2 BPM samples.
// It gives registered random read access by sample age and keeps a running
// sum and moving average of the stored window.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   we, din         - push din as the newest sample
//   clear           - flush history (pointer, count, sum); dout is untouched
//   rd_en, addr_out - read the sample at age addr_out (0 = newest)
//   dout, dout_valid- registered read data and its validity
//   count, full     - number of valid entries, count == DEPTH
//   sum, avg        - sum of valid entries, sum >> DEPTH_LOG2
//   avg_valid       - avg covers a full window
module bpm_history_buffer #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          we,
   input  logic [WIDTH-1:0]              din,
   input  logic                          clear,
   input  logic                          rd_en,
   input  logic [DEPTH_LOG2-1:0]         addr_out,
   output logic [WIDTH-1:0]              dout,
   output logic                          dout_valid,
   output logic [DEPTH_LOG2:0]           count,
   output logic                          full,
   output logic [WIDTH+DEPTH_LOG2-1:0]   sum,
   output logic [WIDTH-1:0]              avg,
   output logic                          avg_valid
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned SW    = WIDTH + DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [SW-1:0]         sum_q, sum_d;
   logic                  full_q, full_d;
   logic [WIDTH-1:0]      dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [SW-1:0]         evict;

   // Next-state logic: read sees pre-edge state, clear beats push.
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      sum_d        = sum_q;
      full_d       = full_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;

      // Age 0 is the slot just behind the write pointer; wrap is natural.
      rd_idx = wr_ptr_q - DEPTH_LOG2'(1) - addr_out;
      // Once full, the slot about to be overwritten leaves the window.
      evict  = full_q ? SW'(mem_q[wr_ptr_q]) : '0;

      if (rd_en) begin
         if (CW'(addr_out) < count_q) begin
            dout_d       = mem_q[rd_idx];
            dout_valid_d = 1'b1;
         end else begin
            dout_d       = '0;
            dout_valid_d = 1'b0;
         end
      end

      if (clear) begin
         wr_ptr_d = '0;
         count_d  = '0;
         sum_d    = '0;
         full_d   = 1'b0;
      end else if (we) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
         if (!full_q) begin
            count_d = count_q + CW'(1);
         end
         sum_d  = sum_q + SW'(din) - evict;
         full_d = (count_d == CW'(DEPTH));
      end
   end

   // Control/status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         count_q      <= '0;
         sum_q        <= '0;
         full_q       <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         sum_q        <= sum_d;
         full_q       <= full_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // Sample storage; not reset, stale data is unreachable once count is 0.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign count      = count_q;
   assign full       = full_q;
   assign sum        = sum_q;
   assign avg        = sum_q[SW-1:DEPTH_LOG2];
   assign avg_valid  = full_q;

endmodule

// File: tb/tb_bpm_history_buffer.sv
// Testbench for bpm_history_buffer: directed vector table, then randomized
// traffic compared against a queue-based model of the sample window.
module tb_bpm_history_buffer;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned DEPTH_LOG2 = 2;
   localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

   logic                        clk = 1'b0;
   logic                        reset, we, clear, rd_en;
   logic [WIDTH-1:0]            din;
   logic [DEPTH_LOG2-1:0]       addr_out;
   logic [WIDTH-1:0]            dout;
   logic                        dout_valid;
   logic [DEPTH_LOG2:0]         count;
   logic                        full;
   logic [WIDTH+DEPTH_LOG2-1:0] sum;
   logic [WIDTH-1:0]            avg;
   logic                        avg_valid;

   int n_cmp = 0;
   int n_err = 0;

   bpm_history_buffer #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk(clk), .reset(reset), .we(we), .din(din), .clear(clear),
      .rd_en(rd_en), .addr_out(addr_out), .dout(dout), .dout_valid(dout_valid),
      .count(count), .full(full), .sum(sum), .avg(avg), .avg_valid(avg_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       rst, clr, w;
      int       d;
      bit       rd;
      int       a;
      int       e_count, e_sum;
      bit       e_full;
      int       e_dout;
      bit       e_dv;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit rst, input bit clr, input bit w, input int d,
                        input bit rd, input int a);
      reset    = rst;
      clear    = clr;
      we       = w;
      din      = WIDTH'(d);
      rd_en    = rd;
      addr_out = DEPTH_LOG2'(a);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int e_count, input int e_sum,
                            input bit e_full, input int e_dout, input bit e_dv);
      chk({tag, " count"}, 32'(count), e_count);
      chk({tag, " sum"}, 32'(sum), e_sum);
      chk({tag, " full"}, 32'(full), 32'(e_full));
      chk({tag, " avg_valid"}, 32'(avg_valid), 32'(e_full));
      chk({tag, " avg"}, 32'(avg), e_sum >> DEPTH_LOG2);
      chk({tag, " dout"}, 32'(dout), e_dout);
      chk({tag, " dout_valid"}, 32'(dout_valid), 32'(e_dv));
   endtask

   function automatic vec_t v(bit rst, bit clr, bit w, int d, bit rd, int a,
                              int ec, int es, bit ef, int ed, bit edv);
      vec_t r;
      r.rst = rst; r.clr = clr; r.w = w; r.d = d; r.rd = rd; r.a = a;
      r.e_count = ec; r.e_sum = es; r.e_full = ef; r.e_dout = ed; r.e_dv = edv;
      return r;
   endfunction

   // Random-phase reference: newest sample at the back of the queue.
   int  mq[$];
   int  m_dout;
   bit  m_dv;

   initial begin
      reset = 1'b1; clear = 1'b0; we = 1'b0; din = '0; rd_en = 1'b0; addr_out = '0;

      //        rst clr we din rd a  count sum full dout dv
      vecs.push_back(v(1, 0, 0,   0, 0, 0, 0,    0, 0,   0, 0));
      vecs.push_back(v(1, 0, 0,   0, 0, 0, 0,    0, 0,   0, 0));
      vecs.push_back(v(0, 0, 0,   0, 1, 0, 0,    0, 0,   0, 0));
      vecs.push_back(v(0, 0, 1,  60, 0, 0, 1,   60, 0,   0, 0));
      vecs.push_back(v(0, 0, 1,  70, 0, 0, 2,  130, 0,   0, 0));
      vecs.push_back(v(0, 0, 1,  80, 0, 0, 3,  210, 0,   0, 0));
      vecs.push_back(v(0, 0, 0,   0, 1, 0, 3,  210, 0,  80, 1));
      vecs.push_back(v(0, 0, 0,   0, 1, 2, 3,  210, 0,  60, 1));
      vecs.push_back(v(0, 0, 0,   0, 1, 3, 3,  210, 0,   0, 0));
      vecs.push_back(v(0, 0, 1,  90, 0, 0, 4,  300, 1,   0, 0));
      vecs.push_back(v(0, 0, 1, 100, 0, 0, 4,  340, 1,   0, 0));
      vecs.push_back(v(0, 0, 0,   0, 1, 3, 4,  340, 1,  70, 1));
      vecs.push_back(v(0, 0, 1, 110, 1, 0, 4,  380, 1, 100, 1));
      vecs.push_back(v(0, 0, 0,   0, 1, 0, 4,  380, 1, 110, 1));
      vecs.push_back(v(0, 1, 1, 200, 0, 0, 0,    0, 0, 110, 1));
      vecs.push_back(v(0, 0, 1, 255, 0, 0, 1,  255, 0, 110, 1));
      vecs.push_back(v(0, 0, 1, 255, 0, 0, 2,  510, 0, 110, 1));
      vecs.push_back(v(0, 0, 1, 255, 0, 0, 3,  765, 0, 110, 1));
      vecs.push_back(v(0, 0, 1, 255, 0, 0, 4, 1020, 1, 110, 1));
      vecs.push_back(v(0, 0, 0,   0, 1, 3, 4, 1020, 1, 255, 1));
      vecs.push_back(v(1, 0, 0,   0, 0, 0, 0,    0, 0,   0, 0));
      vecs.push_back(v(0, 0, 1,  72, 0, 0, 1,   72, 0,   0, 0));
      vecs.push_back(v(0, 0, 0,   0, 1, 0, 1,   72, 0,  72, 1));
      // Clear and read together: read uses the pre-clear count.
      vecs.push_back(v(0, 1, 0,   0, 1, 0, 0,    0, 0,  72, 1));
      vecs.push_back(v(0, 0, 0,   0, 1, 0, 0,    0, 0,   0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].clr, vecs[i].w, vecs[i].d, vecs[i].rd, vecs[i].a);
         check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_sum,
                   vecs[i].e_full, vecs[i].e_dout, vecs[i].e_dv);
      end

      // Hand-written wrap sequence: fill twice over, then read every age.
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2 * DEPTH + 1; i++) drive(0, 0, 1, 10 + i, 0, 0);
      for (int a = 0; a < DEPTH; a++) begin
         drive(0, 0, 0, 0, 1, a);
         chk($sformatf("wrap age%0d", a), 32'(dout), 10 + 2 * DEPTH - a);
      end

      // Randomized traffic against the queue model.
      drive(1, 0, 0, 0, 0, 0);
      mq.delete();
      m_dout = 0;
      m_dv   = 1'b0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         bit r_rst, r_clr, r_we, r_rd;
         int r_din, r_a, msum;
         r_rst = ($urandom_range(0, 99) < 2);
         r_clr = ($urandom_range(0, 99) < 4);
         r_we  = ($urandom_range(0, 99) < 60);
         r_rd  = ($urandom_range(0, 99) < 50);
         r_din = int'($urandom_range(0, (1 << WIDTH) - 1));
         r_a   = int'($urandom_range(0, DEPTH - 1));

         if (r_rd) begin
            if (r_a < mq.size()) begin
               m_dout = mq[mq.size() - 1 - r_a];
               m_dv   = 1'b1;
            end else begin
               m_dout = 0;
               m_dv   = 1'b0;
            end
         end
         if (r_rst) begin
            mq.delete();
            m_dout = 0;
            m_dv   = 1'b0;
         end else if (r_clr) begin
            mq.delete();
         end else if (r_we) begin
            mq.push_back(r_din);
            if (mq.size() > DEPTH) void'(mq.pop_front());
         end
         msum = 0;
         foreach (mq[k]) msum += mq[k];

         drive(r_rst, r_clr, r_we, r_din, r_rd, r_a);
         check_all($sformatf("rnd%0d", cyc), mq.size(), msum,
                   mq.size() == DEPTH, m_dout, m_dv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
